network_batch_sequencer: RTL and testbench

//  Batch inference controller between the CSR/AXI side and NETWORK. Buffers up to DEPTH input

---
 rtl/network_batch_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_network_batch_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_batch_sequencer.sv
// Batch inference sequencer: buffers input vectors, launches NETWORK one vector at a time
// with a response timeout, and queues the results in a first-word fall-through output FIFO.
module network_batch_sequencer #(
    parameter int NUM_INPUTS     = 3,
    parameter int NUM_OUTPUTS    = 2,
    parameter int WORD_WIDTH     = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic                                START,
    input  logic                                ABORT,
    input  logic [$clog2(DEPTH+1)-1:0]          BATCH_LEN,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0]    IN_DATA,
    input  logic                                IN_VALID,
    output logic                                IN_READY,
    output logic [NUM_INPUTS*WORD_WIDTH-1:0]    NET_VALUES_IN,
    output logic                                NET_VALID_IN,
    input  logic [NUM_OUTPUTS*WORD_WIDTH-1:0]   NET_VALUES_OUT,
    input  logic                                NET_VALID_OUT,
    output logic [NUM_OUTPUTS*WORD_WIDTH-1:0]   OUT_DATA,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                TIMEOUT_ERR,
    output logic [$clog2(DEPTH+1)-1:0]          DONE_COUNT
);
    localparam int IW = NUM_INPUTS * WORD_WIDTH;
    localparam int OW = NUM_OUTPUTS * WORD_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] in_mem_q  [DEPTH];
    logic [IW-1:0] in_mem_d  [DEPTH];
    logic [OW-1:0] out_mem_q [DEPTH];
    logic [OW-1:0] out_mem_d [DEPTH];
    logic [PW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [PW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] net_vals_q, net_vals_d;
    logic          net_valid_q, net_valid_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;

    logic          in_full_s, in_empty_s, out_full_s, out_empty_s;
    logic          in_push_s, out_pop_s, launch_s, flush_s;
    logic [LW-1:0] cnt_inc_s;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB
    assign in_full_s   = (in_wp_q[AW] != in_rp_q[AW]) && (in_wp_q[AW-1:0] == in_rp_q[AW-1:0]);
    assign in_empty_s  = (in_wp_q == in_rp_q);
    assign out_full_s  = (out_wp_q[AW] != out_rp_q[AW]) && (out_wp_q[AW-1:0] == out_rp_q[AW-1:0]);
    assign out_empty_s = (out_wp_q == out_rp_q);
    assign in_push_s   = IN_VALID && !in_full_s && !ABORT;
    assign out_pop_s   = !out_empty_s && OUT_READY;
    assign cnt_inc_s   = cnt_q + LW'(1);

    // Next-state logic for the sequencer FSM and both FIFOs
    always_comb begin
        state_d     = state_q;
        in_mem_d    = in_mem_q;
        out_mem_d   = out_mem_q;
        in_wp_d     = in_wp_q;
        in_rp_d     = in_rp_q;
        out_wp_d    = out_wp_q;
        out_rp_d    = out_rp_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        net_vals_d  = net_vals_q;
        net_valid_d = 1'b0;
        done_d      = 1'b0;
        terr_d      = terr_q;
        launch_s    = 1'b0;
        flush_s     = 1'b0;

        if (ABORT) begin
            state_d = ST_IDLE;
            flush_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START && (BATCH_LEN != '0) && (BATCH_LEN <= LW'(DEPTH))) begin
                        state_d = ST_LAUNCH;
                        len_d   = BATCH_LEN;
                        cnt_d   = '0;
                        terr_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    // Only one vector is ever in flight, so a free output slot now suffices
                    if (!in_empty_s && !out_full_s) begin
                        launch_s    = 1'b1;
                        net_vals_d  = in_mem_q[in_rp_q[AW-1:0]];
                        net_valid_d = 1'b1;
                        timer_d     = '0;
                        state_d     = ST_WAIT;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    if (NET_VALID_OUT) begin
                        out_mem_d[out_wp_q[AW-1:0]] = NET_VALUES_OUT;
                        out_wp_d = out_wp_q + PW'(1);
                        cnt_d    = cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LAUNCH;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                        terr_d  = 1'b1;
                        flush_s = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A flush discards queued vectors and any push arriving in the same cycle
        if (flush_s) begin
            in_rp_d = in_wp_q;
        end else begin
            if (in_push_s) begin
                in_mem_d[in_wp_q[AW-1:0]] = IN_DATA;
                in_wp_d = in_wp_q + PW'(1);
            end else begin
                in_wp_d = in_wp_q;
            end
            if (launch_s) begin
                in_rp_d = in_rp_q + PW'(1);
            end else begin
                in_rp_d = in_rp_q;
            end
        end

        if (out_pop_s) begin
            out_rp_d = out_rp_q + PW'(1);
        end else begin
            out_rp_d = out_rp_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                in_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
            in_wp_q     <= '0;
            in_rp_q     <= '0;
            out_wp_q    <= '0;
            out_rp_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            net_vals_q  <= '0;
            net_valid_q <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_mem_q    <= in_mem_d;
            out_mem_q   <= out_mem_d;
            in_wp_q     <= in_wp_d;
            in_rp_q     <= in_rp_d;
            out_wp_q    <= out_wp_d;
            out_rp_q    <= out_rp_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            net_vals_q  <= net_vals_d;
            net_valid_q <= net_valid_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
        end
    end

    assign IN_READY      = !in_full_s;
    assign OUT_VALID     = !out_empty_s;
    assign OUT_DATA      = out_mem_q[out_rp_q[AW-1:0]];
    assign NET_VALUES_IN = net_vals_q;
    assign NET_VALID_IN  = net_valid_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = done_q;
    assign TIMEOUT_ERR   = terr_q;
    assign DONE_COUNT    = cnt_q;

endmodule

// File: tb/tb_network_batch_sequencer.sv
// Directed-plus-random bench for network_batch_sequencer: a queue-based model of the
// vector/result flow and a behavioural NETWORK with programmable latency.
module tb_network_batch_sequencer;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RSTN, START, ABORT, IN_VALID, IN_READY, NET_VALID_IN, NET_VALID_OUT;
    logic        OUT_VALID, OUT_READY, BUSY, DONE, TIMEOUT_ERR;
    logic [2:0]  BATCH_LEN, DONE_COUNT;
    logic [23:0] IN_DATA, NET_VALUES_IN;
    logic [15:0] NET_VALUES_OUT, OUT_DATA;

    network_batch_sequencer dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .ABORT(ABORT), .BATCH_LEN(BATCH_LEN),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .NET_VALUES_IN(NET_VALUES_IN), .NET_VALID_IN(NET_VALID_IN),
        .NET_VALUES_OUT(NET_VALUES_OUT), .NET_VALID_OUT(NET_VALID_OUT),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .BUSY(BUSY), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR), .DONE_COUNT(DONE_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int net_lat, net_cnt, nvi_cnt, done_cnt;
    bit net_mute;
    logic [23:0] net_held;
    logic [23:0] mdl_in[$], exp_launch[$], launched_q[$];
    logic [15:0] mdl_out[$];

    // NETWORK transfer function: word0 = in0 + in1, word1 = in2 ^ 0x5A
    function automatic logic [15:0] net_fn(input logic [23:0] v);
        logic [7:0] w0, w1;
        w0 = v[7:0] + v[15:8];
        w1 = v[23:16] ^ 8'h5A;
        return {w1, w0};
    endfunction

    // Behavioural NETWORK: answers net_lat cycles after the launch strobe (0 = same cycle)
    always @(negedge CLK) begin
        if (!RSTN) begin
            net_cnt = 0;
            NET_VALID_OUT = 1'b0;
        end else begin
            NET_VALID_OUT = 1'b0;
            if (net_cnt > 0) begin
                net_cnt = net_cnt - 1;
                if (net_cnt == 0) begin
                    NET_VALID_OUT = 1'b1;
                    NET_VALUES_OUT = net_fn(net_held);
                end
            end
            if (NET_VALID_IN && !net_mute) begin
                net_held = NET_VALUES_IN;
                if (net_lat == 0) begin
                    NET_VALID_OUT = 1'b1;
                    NET_VALUES_OUT = net_fn(net_held);
                end else begin
                    net_cnt = net_lat;
                end
            end
        end
    end

    // Record launch strobes (with their vectors) and DONE pulses
    always @(posedge CLK) begin
        if (RSTN) begin
            if (NET_VALID_IN) begin
                nvi_cnt++;
                launched_q.push_back(NET_VALUES_IN);
            end
            if (DONE) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push_vec(input string tag);
        logic [23:0] v;
        bit room;
        v = 24'($urandom);
        room = (mdl_in.size() < DEPTH);
        check({tag, "_ready"}, 32'(IN_READY), 32'(room));
        IN_VALID = 1'b1;
        IN_DATA  = v;
        if (room) mdl_in.push_back(v);
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic start_batch(input logic [2:0] len);
        START = 1'b1;
        BATCH_LEN = len;
        tick();
        START = 1'b0;
    endtask

    task automatic model_run(input int n);
        logic [23:0] v;
        for (int i = 0; i < n; i++) begin
            v = mdl_in.pop_front();
            exp_launch.push_back(v);
            mdl_out.push_back(net_fn(v));
        end
    endtask

    task automatic launch_only();
        exp_launch.push_back(mdl_in.pop_front());
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (BUSY === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(BUSY), 32'(1'b0));
        tick();
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e = 16'hxxxx;
        if (mdl_out.size() > 0) e = mdl_out.pop_front();
        check({tag, "_valid"}, 32'(OUT_VALID), 32'(1'b1));
        check({tag, "_data"}, 32'(OUT_DATA), 32'(e));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic cmp_launches(input string tag);
        check({tag, "_n"}, 32'(launched_q.size()), 32'(exp_launch.size()));
        while (exp_launch.size() > 0 && launched_q.size() > 0)
            check(tag, 32'(launched_q.pop_front()), 32'(exp_launch.pop_front()));
        exp_launch.delete();
        launched_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(IN_READY), 32'(1'b1));
        check({tag, "_busy"},      32'(BUSY), 32'(1'b0));
        check({tag, "_out_valid"}, 32'(OUT_VALID), 32'(1'b0));
        check({tag, "_out_data"},  32'(OUT_DATA), 32'(16'h0000));
        check({tag, "_nvi"},       32'(NET_VALID_IN), 32'(1'b0));
        check({tag, "_nvals"},     32'(NET_VALUES_IN), 32'(24'h000000));
        check({tag, "_done"},      32'(DONE), 32'(1'b0));
        check({tag, "_terr"},      32'(TIMEOUT_ERR), 32'(1'b0));
        check({tag, "_dcount"},    32'(DONE_COUNT), 32'(3'd0));
    endtask

    initial begin
        int n;
        RSTN = 1'b0; START = 1'b0; ABORT = 1'b0; BATCH_LEN = 3'd0;
        IN_DATA = 24'h0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        NET_VALUES_OUT = 16'h0; NET_VALID_OUT = 1'b0;
        net_lat = 4; net_mute = 1'b0; net_cnt = 0;
        nvi_cnt = 0; done_cnt = 0;
        repeat (3) tick();
        check_reset("rst");
        RSTN = 1'b1;
        tick();

        // Basic batch of three, 4-cycle NETWORK latency
        nvi_cnt = 0; done_cnt = 0;
        repeat (3) push_vec("t1_push");
        start_batch(3'd3);
        model_run(3);
        wait_idle("t1", 200);
        check("t1_nvi", 32'(nvi_cnt), 32'd3);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_dcount", 32'(DONE_COUNT), 32'd3);
        cmp_launches("t1_launch");
        repeat (3) pop_check("t1_out");
        check("t1_out_empty", 32'(OUT_VALID), 32'(1'b0));

        // Fill input FIFO; fifth push refused
        repeat (4) push_vec("t2_push");
        check("t2_full", 32'(IN_READY), 32'(1'b0));
        push_vec("t2_push5");
        check("t2_still_full", 32'(IN_READY), 32'(1'b0));

        // Output FIFO back-pressure stalls the next batch in LAUNCH
        net_lat = 2; nvi_cnt = 0; done_cnt = 0;
        start_batch(3'd4);
        model_run(4);
        wait_idle("t3a", 300);
        check("t3_dcount4", 32'(DONE_COUNT), 32'd4);
        check("t3_out_valid", 32'(OUT_VALID), 32'(1'b1));
        check("t3_in_ready", 32'(IN_READY), 32'(1'b1));
        push_vec("t3_push");
        start_batch(3'd1);
        repeat (10) tick();
        check("t3_stall_busy", 32'(BUSY), 32'(1'b1));
        check("t3_stall_nvi", 32'(nvi_cnt), 32'd4);
        check("t3_stall_dcount", 32'(DONE_COUNT), 32'd0);
        pop_check("t3_pop");
        model_run(1);
        wait_idle("t3b", 100);
        check("t3_dcount1", 32'(DONE_COUNT), 32'd1);
        check("t3_nvi", 32'(nvi_cnt), 32'd5);
        check("t3_done", 32'(done_cnt), 32'd2);
        cmp_launches("t3_launch");
        repeat (4) pop_check("t3_out");
        check("t3_out_empty", 32'(OUT_VALID), 32'(1'b0));

        // Silent NETWORK: timeout after 64 WAIT cycles
        net_mute = 1'b1; nvi_cnt = 0; done_cnt = 0;
        repeat (2) push_vec("t4_push");
        start_batch(3'd2);
        launch_only();
        mdl_in.delete();
        repeat (64) tick();
        check("t4_busy_63", 32'(BUSY), 32'(1'b1));
        check("t4_terr_63", 32'(TIMEOUT_ERR), 32'(1'b0));
        tick();
        check("t4_busy_64", 32'(BUSY), 32'(1'b0));
        check("t4_terr_64", 32'(TIMEOUT_ERR), 32'(1'b1));
        tick();
        check("t4_nvi", 32'(nvi_cnt), 32'd1);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_no_result", 32'(OUT_VALID), 32'(1'b0));
        cmp_launches("t4_launch");
        start_batch(3'd0);
        check("t4_len0_busy", 32'(BUSY), 32'(1'b0));
        check("t4_len0_terr", 32'(TIMEOUT_ERR), 32'(1'b1));
        start_batch(3'd5);
        check("t4_len5_busy", 32'(BUSY), 32'(1'b0));
        check("t4_len5_terr", 32'(TIMEOUT_ERR), 32'(1'b1));
        net_mute = 1'b0;
        start_batch(3'd1);
        check("t4_clear_terr", 32'(TIMEOUT_ERR), 32'(1'b0));
        check("t4_clear_busy", 32'(BUSY), 32'(1'b1));
        repeat (8) tick();
        check("t4_flushed", 32'(nvi_cnt), 32'd1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t4_abort_busy", 32'(BUSY), 32'(1'b0));

        // ABORT during the second WAIT; late result and ABORT-cycle push both dropped
        net_lat = 4; nvi_cnt = 0; done_cnt = 0;
        repeat (3) push_vec("t5_push");
        start_batch(3'd3);
        n = 0;
        while (DONE_COUNT !== 3'd1 && n < 100) begin tick(); n++; end
        check("t5_first", 32'(DONE_COUNT), 32'd1);
        n = 0;
        while (NET_VALID_IN !== 1'b1 && n < 20) begin tick(); n++; end
        check("t5_second_launch", 32'(NET_VALID_IN), 32'(1'b1));
        model_run(1);
        launch_only();
        mdl_in.delete();
        ABORT = 1'b1; IN_VALID = 1'b1; IN_DATA = 24'($urandom);
        tick();
        ABORT = 1'b0; IN_VALID = 1'b0;
        check("t5_abort_busy", 32'(BUSY), 32'(1'b0));
        check("t5_abort_dcount", 32'(DONE_COUNT), 32'd1);
        check("t5_abort_nvi", 32'(NET_VALID_IN), 32'(1'b0));
        repeat (8) tick();
        check("t5_no_done", 32'(done_cnt), 32'd0);
        cmp_launches("t5_launch");
        pop_check("t5_out");
        check("t5_late_dropped", 32'(OUT_VALID), 32'(1'b0));
        nvi_cnt = 0;
        start_batch(3'd1);
        repeat (6) tick();
        check("t5_in_empty_busy", 32'(BUSY), 32'(1'b1));
        check("t5_in_empty_nvi", 32'(nvi_cnt), 32'd0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;

        // Asynchronous reset mid-WAIT, then a clean batch with same-cycle response
        net_lat = 3; nvi_cnt = 0; done_cnt = 0;
        repeat (2) push_vec("t6_push");
        start_batch(3'd2);
        n = 0;
        while (NET_VALID_IN !== 1'b1 && n < 20) begin tick(); n++; end
        launch_only();
        repeat (2) tick();
        check("t6_mid_wait", 32'(BUSY), 32'(1'b1));
        cmp_launches("t6_launch_pre");
        RSTN = 1'b0;
        #1;
        check_reset("t6_rst");
        mdl_in.delete();
        mdl_out.delete();
        tick();
        RSTN = 1'b1;
        tick();
        net_lat = 0; nvi_cnt = 0; done_cnt = 0;
        repeat (2) push_vec("t6_push2");
        start_batch(3'd2);
        model_run(2);
        wait_idle("t6b", 100);
        check("t6_dcount", 32'(DONE_COUNT), 32'd2);
        check("t6_done", 32'(done_cnt), 32'd1);
        check("t6_terr", 32'(TIMEOUT_ERR), 32'(1'b0));
        cmp_launches("t6_launch");
        repeat (2) pop_check("t6_out");
        check("t6_out_empty", 32'(OUT_VALID), 32'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
